// File: rtl/muldiv_if.sv
// Issue/write-back bundle between the register-file control logic and the multiply/divide unit.
interface muldiv_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 5
) ();
  logic             START;
  logic [1:0]       OP;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [AW-1:0]    DEST;
  logic             BUSY;
  logic             WE;
  logic [AW-1:0]    WR;
  logic [WIDTH-1:0] WD;

  modport master (output START, OP, A, B, DEST, input  BUSY, WE, WR, WD);
  modport slave  (input  START, OP, A, B, DEST, output BUSY, WE, WR, WD);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU unit: WIDTH iteration cycles, then one registered
// register-file write. acc/lo hold {hi,lo} of the product or {remainder,quotient}.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic     CLK,
  input  logic     RST_N,
  muldiv_if.slave  bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [AW-1:0]    dest_q, dest_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             we_q, we_d;
  logic [AW-1:0]    wr_q, wr_d;
  logic [WIDTH-1:0] wd_q, wd_d;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      dest_q  <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      we_q    <= 1'b0;
      wr_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      dest_q  <= dest_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      we_q    <= we_d;
      wr_q    <= wr_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.START) state_d = S_RUN;
      S_RUN:   if (cnt_q == CW'(WIDTH - 1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    op_d   = op_q;
    dest_d = dest_q;
    b_d    = b_q;
    acc_d  = acc_q;
    lo_d   = lo_q;
    we_d   = 1'b0;
    wr_d   = wr_q;
    wd_d   = wd_q;
    sum    = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    rem_sh = {acc_q, lo_q[WIDTH-1]};
    unique case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          op_d   = bus.OP;
          dest_d = bus.DEST;
          b_d    = bus.B;
          acc_d  = '0;
          lo_d   = bus.A;
          cnt_d  = '0;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (!op_q[1]) begin
          // Shift-add: product high half in acc, multiplier bits consumed from lo's LSB.
          acc_d = sum[WIDTH:1];
          lo_d  = {sum[0], lo_q[WIDTH-1:1]};
        end else if (rem_sh >= {1'b0, b_q}) begin
          acc_d = WIDTH'(rem_sh - {1'b0, b_q});
          lo_d  = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = rem_sh[WIDTH-1:0];
          lo_d  = {lo_q[WIDTH-2:0], 1'b0};
        end
      end
      S_DONE: begin
        if (dest_q != '0) begin
          we_d = 1'b1;
          wr_d = dest_q;
          wd_d = op_q[0] ? acc_q : lo_q;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.BUSY = (state_q != S_IDLE);
    bus.WE   = we_q;
    bus.WR   = wr_q;
    bus.WD   = wd_q;
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
  logic CLK;
  logic RST_N;
  int   errors = 0;
  int   checks = 0;

  muldiv_if #(.WIDTH(32), .AW(5)) bus ();
  muldiv_unit #(.WIDTH(32), .AW(5)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    case (op)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge with the unit idle. Samples 36 negedges after the accept edge.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] dest, input bit poke, input string tag);
    int busy_cnt = 0;
    int we_cnt   = 0;
    int we_n     = -1;
    logic [31:0] wd = '0;
    logic [4:0]  wr = '0;
    bus.START = 1'b1; bus.OP = op; bus.A = a; bus.B = b; bus.DEST = dest;
    @(posedge CLK);
    #1;
    bus.START = 1'b0; bus.OP = 2'($urandom); bus.A = $urandom; bus.B = $urandom; bus.DEST = 5'($urandom);
    for (int n = 0; n < 36; n++) begin
      @(negedge CLK);
      if (bus.BUSY) busy_cnt++;
      if (bus.WE) begin
        we_cnt++; we_n = n; wd = bus.WD; wr = bus.WR;
      end
      bus.START = poke && (n == 5 || n == 20 || n == 32);
      bus.A = $urandom; bus.B = $urandom; bus.OP = 2'($urandom); bus.DEST = 5'($urandom);
    end
    bus.START = 1'b0;
    chk({tag, ".busy_cycles"}, 64'(busy_cnt), 64'd33);
    chk({tag, ".we_count"}, 64'(we_cnt), (dest != 0) ? 64'd1 : 64'd0);
    if (dest != 0) begin
      chk({tag, ".we_latency"}, 64'(we_n), 64'd33);
      chk({tag, ".wr"}, 64'(wr), 64'(dest));
      chk({tag, ".wd"}, 64'(wd), 64'(ref_res(op, a, b)));
    end
  endtask

  initial begin
    int we_cnt, we_n1, we_n2;
    logic [31:0] wd1, wd2;
    logic [4:0]  wr1, wr2;
    logic busy33, busy34;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    RST_N = 1'b0;
    bus.START = 1'b0; bus.OP = '0; bus.A = '0; bus.B = '0; bus.DEST = '0;
    repeat (3) @(negedge CLK);
    chk("reset.busy", 64'(bus.BUSY), 64'd0);
    chk("reset.we", 64'(bus.WE), 64'd0);
    chk("reset.wr", 64'(bus.WR), 64'd0);
    chk("reset.wd", 64'(bus.WD), 64'd0);
    RST_N = 1'b1;
    @(negedge CLK);

    run_op(2'd0, 32'd7, 32'd6, 5'd5, 1'b0, "mul7x6");
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 1'b0, "mulhu_max");
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 1'b0, "mul_max");
    run_op(2'd2, 32'd100, 32'd7, 5'd11, 1'b0, "divu100_7");
    run_op(2'd3, 32'd100, 32'd7, 5'd11, 1'b0, "remu100_7");
    run_op(2'd2, 32'd5, 32'd0, 5'd12, 1'b0, "divu_by0");
    run_op(2'd3, 32'd5, 32'd0, 5'd13, 1'b0, "remu_by0");
    run_op(2'd0, 32'd3, 32'd4, 5'd6, 1'b1, "mul_start_ignored");
    run_op(2'd0, 32'd9, 32'd9, 5'd0, 1'b0, "dest0");

    // START held high across the write-back: second op accepted as soon as the unit is idle.
    we_cnt = 0; we_n1 = -1; we_n2 = -1; wd1 = '0; wd2 = '0; wr1 = '0; wr2 = '0;
    busy33 = 1'b1; busy34 = 1'b0;
    bus.START = 1'b1; bus.OP = 2'd0; bus.A = 32'd11; bus.B = 32'd13; bus.DEST = 5'd3;
    @(posedge CLK);
    #1;
    bus.OP = 2'd2; bus.A = 32'd1000; bus.B = 32'd33; bus.DEST = 5'd4;
    for (int n = 0; n < 72; n++) begin
      @(negedge CLK);
      if (n == 33) busy33 = bus.BUSY;
      if (n == 34) busy34 = bus.BUSY;
      if (bus.WE) begin
        we_cnt++;
        if (we_n1 < 0) begin we_n1 = n; wd1 = bus.WD; wr1 = bus.WR; end
        else begin we_n2 = n; wd2 = bus.WD; wr2 = bus.WR; end
      end
      if (n == 40) bus.START = 1'b0;
    end
    chk("b2b.we_count", 64'(we_cnt), 64'd2);
    chk("b2b.first_lat", 64'(we_n1), 64'd33);
    chk("b2b.first_wd", 64'(wd1), 64'd143);
    chk("b2b.first_wr", 64'(wr1), 64'd3);
    chk("b2b.busy_wb_cycle", 64'(busy33), 64'd0);
    chk("b2b.busy_reaccept", 64'(busy34), 64'd1);
    chk("b2b.second_lat", 64'(we_n2), 64'd67);
    chk("b2b.second_wd", 64'(wd2), 64'd30);
    chk("b2b.second_wr", 64'(wr2), 64'd4);

    // Asynchronous reset in the middle of RUN.
    bus.START = 1'b1; bus.OP = 2'd0; bus.A = 32'd123; bus.B = 32'd456; bus.DEST = 5'd9;
    @(posedge CLK);
    #1 bus.START = 1'b0;
    repeat (10) @(negedge CLK);
    chk("abort.busy_before", 64'(bus.BUSY), 64'd1);
    RST_N = 1'b0;
    #1;
    chk("abort.busy", 64'(bus.BUSY), 64'd0);
    chk("abort.we", 64'(bus.WE), 64'd0);
    chk("abort.wd_cleared", 64'(bus.WD), 64'd0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    we_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge CLK);
      if (bus.WE || bus.BUSY) we_cnt++;
    end
    chk("abort.no_writeback", 64'(we_cnt), 64'd0);
    run_op(2'd0, 32'd2, 32'd3, 5'd7, 1'b0, "after_abort_mul");

    for (int i = 0; i < 10; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      run_op(rop, ra, rb, 5'($urandom_range(1, 31)), 1'b0, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
